ad9361_tx_framer: RTL and testbench
===================================

// Module: ad9361_tx_framer
// PURPOSE
//  Transmit-side framer for the AD9361 1R1T data port: accepts 12-bit I/Q samples on a
//  valid/ready stream and serialises each into four 6-bit lane words with a frame strobe.
//  Sits between the TX DMA/sample FIFO and the LVDS output primitives.
//  Emits the same frame/lane format that the RX path and its bench stimulus consume.
// PARAMETERS
//  LANE_W   6   lane width in bits; sample width is 2*LANE_W
//  UFLOW_W  16  width of the saturating underflow counter
// PORTS
//  clk            in   1         framer clock, one lane word per cycle
//  rst            in   1         synchronous, active-high reset
//  tx_enable      in   1         run request (level)
//  s_valid        in   1         sample valid
//  s_ready        out  1         sample accepted when s_valid && s_ready
//  s_i            in   2*LANE_W  I sample (two's complement)
//  s_q            in   2*LANE_W  Q sample (two's complement)
//  cfg_ramp       in   1         select ramp test source (used only with macro)
//  tx_frame       out  1         frame strobe
//  tx_data        out  LANE_W    lane word
//  busy           out  1         high while not IDLE
//  underflow_cnt  out  UFLOW_W   missed-sample count, saturating
// BEHAVIOUR
//  Reset: tx_frame=0, tx_data=0, s_ready=0, busy=0, underflow_cnt=0, state=IDLE,
//   holding regs=0; a reset mid-sample aborts it immediately.
//  States: IDLE, PRIME, RUN (RUN carries 2-bit phase 0..3).
//  IDLE: outputs 0. tx_enable=1 -> PRIME next cycle.
//  PRIME (one cycle): s_ready=1. Load holding reg with the sample or zeros. -> RUN phase 0.
//  RUN phases (all outputs registered):
//   0: data=I[11:6], frame=1
//   1: data=Q[11:6], frame=1
//   2: data=I[5:0],  frame=0
//   3: data=Q[5:0],  frame=0
//  Phase 3 acts as the load slot. If tx_enable=1, s_ready=1 and the next sample is loaded.
//   The next cycle is phase 0, giving gapless back-to-back output.
//  Latency: a sample accepted in cycle N appears as I MSB on tx_data in cycle N+1.
//  Underflow: a load slot (PRIME or phase 3 with enable) with s_valid=0 loads I=Q=0.
//   The frame keeps running and underflow_cnt increments.
//   At all-ones the counter holds (no wrap).
//  Disable: tx_enable sampled low at phase 3 -> s_ready=0, nothing loaded, -> IDLE.
//   The current sample always completes all 4 phases.
//   A tx_enable low pulse shorter than a sample, between load slots, has no effect.
//  s_ready is 0 outside load slots; s_valid in other cycles is ignored and no sample is consumed.
//  busy=1 in PRIME and RUN.
// CONFIGURATION
//  TX_FRAMER_RAMP_EN defined: adds a ramp generator.
//   When cfg_ramp=1, load slots take I=Q=ramp value and ignore the stream.
//   s_ready stays 0 and no underflow is counted.
//   The ramp starts at 0 on entry to PRIME and increments by 1 per loaded sample, wrapping at 2^(2*LANE_W).
//  TX_FRAMER_RAMP_EN undefined: cfg_ramp is ignored and no ramp logic is built.
// STRUCTURE
//  Package ad9361_tx_pkg: state enum (IDLE/PRIME/RUN), phase constants
//   PH_I_MSB..PH_Q_LSB, and LANE_W default.
//  Sub-module ad9361_tx_ramp_gen: counter with clear/step, instantiated only under the macro.
// TESTING
//  1 Reset with tx_enable=1 and s_valid=1 -> all outputs 0, s_ready=0 while rst held.
//  2 Enable with one sample I=0xABC, Q=0x123, then valid low ->
//     data 0x2A,0x04,0x3C,0x23 with frame 1,1,0,0.
//     The next sample is zeros and underflow_cnt=1.
//  3 Stream of 3 samples, valid always 1 ->
//     12 consecutive lane words with no gap; s_ready high exactly 3 cycles, 4 apart.
//  4 Force underflow_cnt near max, e.g. 0xFFFE, and run 3 empty slots -> saturates at 0xFFFF.
//  5 Drop tx_enable at phase 1 -> phases 2,3 still emitted, then IDLE, tx_frame=0, busy=0.
//     No extra s_ready.
//  6 (macro) cfg_ramp=1 -> I MSB/LSB words carry 0,1,2,... per sample; s_ready stays 0.

Source files
------------

// File: rtl/ad9361_tx_pkg.sv
// Shared types for the AD9361 1R1T transmit framer.
// Consumed by ad9361_tx_framer and ad9361_tx_ramp_gen.
package ad9361_tx_pkg;

    localparam int TX_LANE_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    typedef logic [1:0] phase_t;

    localparam phase_t PH_I_MSB = 2'd0;
    localparam phase_t PH_Q_MSB = 2'd1;
    localparam phase_t PH_I_LSB = 2'd2;
    localparam phase_t PH_Q_LSB = 2'd3;

endpackage

// File: rtl/ad9361_tx_ramp_gen.sv
// Ramp test source for the TX framer: clear to zero, step by one.
// Instantiated only when TX_FRAMER_RAMP_EN is defined.
module ad9361_tx_ramp_gen #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         step,
    output logic [W-1:0] value
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            value <= '0;
        end else if (step) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/ad9361_tx_framer.sv
// AD9361 1R1T TX framer: one I/Q sample -> four lane words with frame strobe.
// Optional ramp test source enabled by defining TX_FRAMER_RAMP_EN.
module ad9361_tx_framer
    import ad9361_tx_pkg::*;
#(
    parameter int LANE_W  = TX_LANE_W,
    parameter int UFLOW_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tx_enable,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [2*LANE_W-1:0] s_i,
    input  logic [2*LANE_W-1:0] s_q,
    input  logic                cfg_ramp,
    output logic                tx_frame,
    output logic [LANE_W-1:0]   tx_data,
    output logic                busy,
    output logic [UFLOW_W-1:0]  underflow_cnt
);

    localparam int SW = 2 * LANE_W;

    state_t            state, state_nx;
    phase_t            phase, phase_nx;
    logic [SW-1:0]     hold_i, hold_q;
    logic [SW-1:0]     hold_i_nx, hold_q_nx;
    logic [SW-1:0]     ramp_val;
    logic              use_ramp;
    logic              slot;
    logic              uflow;
    logic [LANE_W-1:0] data_nx;
    logic              frame_nx;

`ifdef TX_FRAMER_RAMP_EN
    assign use_ramp = cfg_ramp;

    ad9361_tx_ramp_gen #(
        .W(SW)
    ) u_ramp (
        .clk  (clk),
        .rst  (rst),
        .clear(state == IDLE),
        .step (slot && cfg_ramp),
        .value(ramp_val)
    );
`else
    logic unused_cfg_ramp;
    assign unused_cfg_ramp = cfg_ramp;
    assign use_ramp        = 1'b0;
    assign ramp_val        = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            phase <= PH_I_MSB;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
        end
    end

    // Phase 3 doubles as the load slot so samples run back to back.
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        slot     = 1'b0;
        unique case (state)
            IDLE: begin
                phase_nx = PH_I_MSB;
                if (tx_enable) state_nx = PRIME;
            end
            PRIME: begin
                slot     = 1'b1;
                state_nx = RUN;
                phase_nx = PH_I_MSB;
            end
            RUN: begin
                phase_nx = phase + 2'd1;
                if (phase == PH_Q_LSB) begin
                    slot = tx_enable;
                    if (!tx_enable) state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                phase_nx = PH_I_MSB;
            end
        endcase
    end

    always_comb begin
        s_ready   = slot && !use_ramp;
        uflow     = slot && !use_ramp && !s_valid;
        busy      = (state != IDLE);
        hold_i_nx = hold_i;
        hold_q_nx = hold_q;
        if (slot) begin
            if (use_ramp) begin
                hold_i_nx = ramp_val;
                hold_q_nx = ramp_val;
            end else if (s_valid) begin
                hold_i_nx = s_i;
                hold_q_nx = s_q;
            end else begin
                hold_i_nx = '0;
                hold_q_nx = '0;
            end
        end
        data_nx  = '0;
        frame_nx = 1'b0;
        if (state_nx == RUN) begin
            unique case (phase_nx)
                PH_I_MSB: begin
                    data_nx  = hold_i_nx[SW-1:LANE_W];
                    frame_nx = 1'b1;
                end
                PH_Q_MSB: begin
                    data_nx  = hold_q_nx[SW-1:LANE_W];
                    frame_nx = 1'b1;
                end
                PH_I_LSB: data_nx = hold_i_nx[LANE_W-1:0];
                PH_Q_LSB: data_nx = hold_q_nx[LANE_W-1:0];
                default:  data_nx = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_i        <= '0;
            hold_q        <= '0;
            tx_data       <= '0;
            tx_frame      <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            hold_i   <= hold_i_nx;
            hold_q   <= hold_q_nx;
            tx_data  <= data_nx;
            tx_frame <= frame_nx;
            if (uflow && (underflow_cnt != '1)) begin
                underflow_cnt <= underflow_cnt + UFLOW_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ad9361_tx_framer.sv
// Randomised bench for ad9361_tx_framer against a sample-level reference model.
// Ramp checks are added when TX_FRAMER_RAMP_EN is defined.
module tb_ad9361_tx_framer;

    localparam int LW   = 6;
    localparam int UW   = 8;
    localparam int SW   = 2 * LW;
    localparam int UMAX = (1 << UW) - 1;
    localparam int SMOD = 1 << SW;
    localparam int LMOD = 1 << LW;
`ifdef TX_FRAMER_RAMP_EN
    localparam bit RAMP_BUILD = 1'b1;
`else
    localparam bit RAMP_BUILD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_enable;
    logic          s_valid;
    logic          s_ready;
    logic [SW-1:0] s_i;
    logic [SW-1:0] s_q;
    logic          cfg_ramp;
    logic          tx_frame;
    logic [LW-1:0] tx_data;
    logic          busy;
    logic [UW-1:0] underflow_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: 0 idle, 1 prime, 2 run; pos = word index in the sample.
    int m_mode;
    int m_pos;
    int m_cnt;
    int m_ramp;
    int m_w[4];

    ad9361_tx_framer #(
        .LANE_W (LW),
        .UFLOW_W(UW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_enable    (tx_enable),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_i          (s_i),
        .s_q          (s_q),
        .cfg_ramp     (cfg_ramp),
        .tx_frame     (tx_frame),
        .tx_data      (tx_data),
        .busy         (busy),
        .underflow_cnt(underflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ramp_on();
        return RAMP_BUILD && cfg_ramp;
    endfunction

    function automatic bit m_slot();
        return (m_mode == 1) || (m_mode == 2 && m_pos == 3 && tx_enable);
    endfunction

    task automatic check_outputs();
        chk("s_ready", int'(s_ready), int'(m_slot() && !ramp_on()));
        chk("tx_data", int'(tx_data), (m_mode == 2) ? m_w[m_pos] : 0);
        chk("tx_frame", int'(tx_frame), int'(m_mode == 2 && m_pos < 2));
        chk("busy", int'(busy), int'(m_mode != 0));
        chk("uflow_cnt", int'(underflow_cnt), m_cnt);
    endtask

    task automatic mdl_update();
        int si;
        int sq;
        if (rst) begin
            m_mode = 0;
            m_pos  = 0;
            m_cnt  = 0;
            m_ramp = 0;
            return;
        end
        if (m_mode == 0) begin
            m_ramp = 0;
            if (tx_enable) m_mode = 1;
        end else if (m_slot()) begin
            if (ramp_on()) begin
                si     = m_ramp;
                sq     = m_ramp;
                m_ramp = (m_ramp + 1) % SMOD;
            end else if (s_valid) begin
                si = int'(s_i);
                sq = int'(s_q);
            end else begin
                si = 0;
                sq = 0;
                if (m_cnt < UMAX) m_cnt++;
            end
            m_w[0] = si / LMOD;
            m_w[1] = sq / LMOD;
            m_w[2] = si % LMOD;
            m_w[3] = sq % LMOD;
            m_mode = 2;
            m_pos  = 0;
        end else if (m_mode == 2 && m_pos == 3) begin
            m_mode = 0;
        end else begin
            m_pos++;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        mdl_update();
        #1;
    endtask

    initial begin
        int nrdy;
        int first;
        int last;

        rst       = 1'b1;
        tx_enable = 1'b1;
        s_valid   = 1'b1;
        s_i       = 12'hABC;
        s_q       = 12'h123;
        cfg_ramp  = 1'b0;
        foreach (m_w[k]) m_w[k] = 0;
        @(posedge clk);
        mdl_update();
        #1;
        cyc();
        cyc();
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_busy", int'(busy), 0);

        // Single sample followed by an empty slot.
        rst       = 1'b0;
        tx_enable = 1'b0;
        cyc();
        tx_enable = 1'b1;
        cyc();
        chk("prime_ready", int'(s_ready), 1);
        cyc();
        s_valid = 1'b0;
        chk("w0", int'(tx_data), 'h2A);
        chk("f0", int'(tx_frame), 1);
        cyc();
        chk("w1", int'(tx_data), 'h04);
        chk("f1", int'(tx_frame), 1);
        cyc();
        chk("w2", int'(tx_data), 'h3C);
        chk("f2", int'(tx_frame), 0);
        cyc();
        chk("w3", int'(tx_data), 'h23);
        chk("f3", int'(tx_frame), 0);
        cyc();
        chk("empty_w0", int'(tx_data), 0);
        chk("uflow_one", int'(underflow_cnt), 1);
        tx_enable = 1'b0;
        repeat (4) cyc();
        chk("stop_busy", int'(busy), 0);

        // Three back-to-back samples.
        tx_enable = 1'b1;
        s_valid   = 1'b1;
        cyc();
        nrdy  = 0;
        first = -1;
        last  = -1;
        for (int k = 0; k < 13; k++) begin
            if (s_ready) begin
                nrdy++;
                if (first < 0) first = k;
                last = k;
            end
            if (k == 9) tx_enable = 1'b0;
            s_i = SW'($urandom_range(0, SMOD - 1));
            s_q = SW'($urandom_range(0, SMOD - 1));
            cyc();
        end
        chk("b2b_ready_cnt", nrdy, 3);
        chk("b2b_ready_span", last - first, 8);
        chk("b2b_idle", int'(busy), 0);

        // Enable dropped mid-sample.
        tx_enable = 1'b1;
        cyc();
        cyc();
        cyc();
        tx_enable = 1'b0;
        nrdy = 0;
        for (int k = 0; k < 3; k++) begin
            if (s_ready) nrdy++;
            cyc();
        end
        chk("drop_ready", nrdy, 0);
        chk("drop_frame", int'(tx_frame), 0);
        chk("drop_busy", int'(busy), 0);

`ifdef TX_FRAMER_RAMP_EN
        cfg_ramp  = 1'b1;
        tx_enable = 1'b1;
        s_valid   = 1'b1;
        cyc();
        chk("ramp_ready", int'(s_ready), 0);
        for (int n = 0; n < 3; n++) begin
            cyc();
            chk("ramp_imsb", int'(tx_data), 0);
            cyc();
            cyc();
            chk("ramp_ilsb", int'(tx_data), n);
            if (n == 2) tx_enable = 1'b0;
            cyc();
        end
        cyc();
        cfg_ramp = 1'b0;
`endif

        // Underflow saturation.
        tx_enable = 1'b1;
        s_valid   = 1'b0;
        cyc();
        cyc();
        repeat ((UMAX + 6) * 4) cyc();
        chk("uflow_sat", int'(underflow_cnt), UMAX);
        tx_enable = 1'b0;
        repeat (5) cyc();

        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 399) == 0);
            tx_enable = ($urandom_range(0, 9) != 0);
            s_valid   = ($urandom_range(0, 9) < 7);
            s_i       = SW'($urandom_range(0, SMOD - 1));
            s_q       = SW'($urandom_range(0, SMOD - 1));
            if ($urandom_range(0, 49) == 0) cfg_ramp = ~cfg_ramp;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
